dispatcher_for_in_flit: RTL
===========================

// Module: dispatcher_for_IN_flit
// PURPOSE
// Download-side counterpart of the OUT_req arbiter. Pops flits from the IN flit FIFO and steers
// each packet to one of three download regs: inst_cache, data_cache or memory.
// The target comes from the head-flit dest field. The route is held until the tail flit.
// A one-entry output register decouples the FIFO from download-reg back-pressure at 1 flit/cycle.
// PARAMETERS
// FLIT_W    16         flit payload width in bits
// DEST_MSB  FLIT_W-1   MSB of the 2-bit dest field in a head flit: IN_flit[DEST_MSB:DEST_MSB-1]
// PORTS
// clk               in   1       single clock, rising edge
// rst               in   1       asynchronous reset, active-low
// IN_flit_vld       in   1       IN FIFO holds a flit (not empty)
// IN_flit           in   FLIT_W  flit at the FIFO head
// IN_flit_ctrl      in   2       01 head, 10 body, 11 tail (11 in IDLE = single-flit packet), 00 illegal
// ic_download_rdy   in   1       inst_cache download reg can accept a flit this cycle
// dc_download_rdy   in   1       data_cache download reg can accept a flit this cycle
// mem_download_rdy  in   1       memory download reg can accept a flit this cycle
// ack_IN_flit       out  1       pop strobe to the IN FIFO (combinational)
// v_flit_to_ic      out  1       output flit valid for inst_cache
// v_flit_to_dc      out  1       output flit valid for data_cache
// v_flit_to_mem     out  1       output flit valid for memory
// flit_out          out  FLIT_W  registered flit, shared by all three targets
// flit_ctrl_out     out  2       registered ctrl of flit_out
// select            out  3       one-hot target of flit_out: 100 ic, 010 dc, 001 mem, 000 none
// err_bad_dest      out  1       one-cycle pulse: head flit with dest 00 was discarded
// err_seq           out  1       one-cycle pulse: ctrl sequence violation
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, out_v=0. Every output is 0, including ack_IN_flit.
//   A partial packet is abandoned. After release, the first flit is treated as a new head.
// - Dest decode, head flits only: 01 ic, 10 dc, 11 mem, 00 invalid.
// - State machine, one-hot: IDLE, IC_DL, DC_DL, MEM_DL, DROP.
// - Output register: v_flit_to_x = out_v & select[x].
//   acc = out_v & rdy of the selected target. ld = ~out_v | acc.
// - Pop rule: ack_IN_flit = IN_flit_vld & (ld | state==DROP). DROP never loads the output register.
// - On a pop with a forwarded flit, the next edge sets out_v=1 and loads flit_out, flit_ctrl_out and select.
//   On acc with no new pop, out_v clears.
//   Latency is 1 cycle from pop to valid. Back-to-back packets run with no bubble.
// - While out_v=1 and the target is not ready: flit_out, flit_ctrl_out and select hold stable, and no pop occurs.
// - Transitions, evaluated only on a pop:
//   IDLE, ctrl 01, valid dest: forward; go to the matching X_DL.
//   IDLE, ctrl 11, valid dest: forward; stay in IDLE.
//   IDLE, ctrl 01, dest 00: discard; pulse err_bad_dest; go to DROP.
//   IDLE, ctrl 11, dest 00: discard; pulse err_bad_dest; stay in IDLE.
//   IDLE, ctrl 10 or 00: discard; pulse err_seq; stay in IDLE.
//   X_DL, ctrl 10: forward to X.
//   X_DL, ctrl 11: forward to X; go to IDLE.
//   X_DL, ctrl 01: forward as body; pulse err_seq; dest is ignored.
//   X_DL, ctrl 00: discard; pulse err_seq.
//   DROP: pop and discard every cycle IN_flit_vld=1. ctrl 11 goes to IDLE.
// - The route is fixed by the state. In X_DL, select equals X for every forwarded flit.
// - err pulses are registered and asserted the cycle after the offending pop.
// TESTING
// - dc packet {01 dest=10, 10, 11}, dc_rdy=1: 3 pops on consecutive cycles.
//   v_flit_to_dc is high for 3 cycles starting 1 cycle after the first pop; select=010; ends in IDLE.
// - mem packet of 4 flits; mem_rdy=0 for 3 cycles after flit 2: flit_out and ctrl hold, ack_IN_flit=0.
//   All 4 flits are delivered in order with no duplicates.
// - Single flit ctrl=11 dest=01, then a dc head next cycle: one v_flit_to_ic pulse.
//   The dc head is popped back-to-back with no idle cycle.
// - Head 01 dest=00 plus 2 flits {10, 11}: err_bad_dest pulses once, 3 pops occur.
//   No v_flit_to_* is asserted; ends in IDLE.
// - Body flit (10) arriving in IDLE: popped, err_seq pulses 1 cycle, no output valid.
// - rst=0 mid-packet between clock edges: all outputs go to 0 immediately.
//   After release, a new ic head is routed normally with select=100.

Source files
------------

// File: rtl/dispatcher_for_in_flit.sv
// Download-side flit dispatcher: pops the IN flit FIFO and steers each packet to the
// inst_cache, data_cache or memory download register through a one-entry output stage.
module dispatcher_for_in_flit #(
  parameter int FLIT_W   = 16,
  parameter int DEST_MSB = FLIT_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_flit_vld,
  input  logic [FLIT_W-1:0] IN_flit,
  input  logic [1:0]        IN_flit_ctrl,
  input  logic              ic_download_rdy,
  input  logic              dc_download_rdy,
  input  logic              mem_download_rdy,
  output logic              ack_IN_flit,
  output logic              v_flit_to_ic,
  output logic              v_flit_to_dc,
  output logic              v_flit_to_mem,
  output logic [FLIT_W-1:0] flit_out,
  output logic [1:0]        flit_ctrl_out,
  output logic [2:0]        select,
  output logic              err_bad_dest,
  output logic              err_seq
);

  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    IC_DL  = 5'b00010,
    DC_DL  = 5'b00100,
    MEM_DL = 5'b01000,
    DROP   = 5'b10000
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        out_v;
  logic        acc;
  logic        ld;
  logic        pop;
  logic        fwd;
  logic        bad_dest;
  logic        seq_err;
  logic [1:0]  dest;
  logic [1:0]  fwd_ctrl;
  logic [2:0]  head_sel;
  logic [2:0]  route_sel;
  logic [2:0]  fwd_sel;

  // Handshakes: a flit leaves the output stage when v_flit_to_x and x_download_rdy are both
  // high at a rising edge; the FIFO head is consumed when ack_IN_flit is high at a rising edge.
  // A stalled output stage holds flit, ctrl and select and blocks further pops (except DROP).
  assign acc  = out_v & |(select & {ic_download_rdy, dc_download_rdy, mem_download_rdy});
  assign ld   = ~out_v | acc;
  assign pop  = rst & IN_flit_vld & (ld | (state == DROP));
  assign ack_IN_flit = pop;

  assign v_flit_to_ic  = out_v & select[2];
  assign v_flit_to_dc  = out_v & select[1];
  assign v_flit_to_mem = out_v & select[0];

  assign dest = IN_flit[DEST_MSB -: 2];

  always_comb begin
    case (dest)
      2'b01:   head_sel = 3'b100;
      2'b10:   head_sel = 3'b010;
      2'b11:   head_sel = 3'b001;
      default: head_sel = 3'b000;
    endcase
  end

  always_comb begin
    case (state)
      IC_DL:   route_sel = 3'b100;
      DC_DL:   route_sel = 3'b010;
      MEM_DL:  route_sel = 3'b001;
      default: route_sel = 3'b000;
    endcase
  end

  // Decision for the flit at the FIFO head; only takes effect when it is popped.
  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    fwd_sel   = route_sel;
    fwd_ctrl  = IN_flit_ctrl;
    bad_dest  = 1'b0;
    seq_err   = 1'b0;
    case (state)
      IDLE: begin
        if (IN_flit_ctrl == CTRL_HEAD || IN_flit_ctrl == CTRL_TAIL) begin
          if (head_sel != 3'b000) begin
            fwd     = 1'b1;
            fwd_sel = head_sel;
            if (IN_flit_ctrl == CTRL_HEAD) begin
              case (dest)
                2'b01:   state_nxt = IC_DL;
                2'b10:   state_nxt = DC_DL;
                default: state_nxt = MEM_DL;
              endcase
            end
          end else begin
            bad_dest = 1'b1;
            if (IN_flit_ctrl == CTRL_HEAD) state_nxt = DROP;
          end
        end else begin
          seq_err = 1'b1;
        end
      end
      IC_DL, DC_DL, MEM_DL: begin
        case (IN_flit_ctrl)
          CTRL_BODY: fwd = 1'b1;
          CTRL_TAIL: begin
            fwd       = 1'b1;
            state_nxt = IDLE;
          end
          CTRL_HEAD: begin
            // A stray head inside a packet stays on the current route as a body flit.
            fwd      = 1'b1;
            fwd_ctrl = CTRL_BODY;
            seq_err  = 1'b1;
          end
          default: seq_err = 1'b1;
        endcase
      end
      DROP: begin
        if (IN_flit_ctrl == CTRL_TAIL) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      out_v         <= 1'b0;
      flit_out      <= '0;
      flit_ctrl_out <= 2'b00;
      select        <= 3'b000;
      err_bad_dest  <= 1'b0;
      err_seq       <= 1'b0;
    end else begin
      err_bad_dest <= pop & bad_dest;
      err_seq      <= pop & seq_err;
      if (pop) state <= state_nxt;
      if (pop & fwd) begin
        out_v         <= 1'b1;
        flit_out      <= IN_flit;
        flit_ctrl_out <= fwd_ctrl;
        select        <= fwd_sel;
      end else if (acc) begin
        out_v  <= 1'b0;
        select <= 3'b000;
      end
    end
  end

endmodule
